// File: rtl/light_pkg.sv
// Shared constants for the RGB PWM driver: level width,
// byte-slice positions within the 24-bit colour word, and a full-white value.
package light_pkg;

    localparam int PWM_W = 8;

    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    localparam logic [23:0] WHITE = 24'hFF_FFFF;

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: level register with optional step-limited fade,
// and a registered compare against the shared period counter.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   enable   in   0 forces the output low
//   update   in   period-end strobe; level moves toward target on this edge
//   target   in   requested level
//   pwm_cnt  in   shared period counter
//   level    out  current (faded) level
//   pwm      out  registered PWM drive
module pwm_channel
    import light_pkg::*;
#(
    parameter bit          FADE_EN   = 1'b1,
    parameter int unsigned FADE_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             update,
    input  logic [PWM_W-1:0] target,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic [PWM_W-1:0] level,
    output logic             pwm
);

    localparam logic [PWM_W-1:0] STEP = PWM_W'(FADE_STEP);

    logic [PWM_W-1:0] r_level;
    logic             r_pwm;
    logic [PWM_W-1:0] w_next_level;
    logic [PWM_W-1:0] w_diff;
    logic             w_up;

    // Distance is computed unsigned in the direction of travel, so a
    // step larger than the remaining gap snaps to target instead of
    // wrapping past 0 or 255.
    always_comb begin
        w_up         = (target > r_level);
        w_diff       = w_up ? (target - r_level) : (r_level - target);
        w_next_level = target;
        if (FADE_EN && (w_diff > STEP)) begin
            w_next_level = w_up ? (r_level + STEP) : (r_level - STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else if (update) begin
            r_level <= w_next_level;
        end
    end

    // Compare uses the level held before any same-edge update; at the
    // period-end edge pwm_cnt is 255, so the result is low either way.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= enable && (pwm_cnt < r_level);
        end
    end

    assign level = r_level;
    assign pwm   = r_pwm;

endmodule

// File: rtl/light_pwm_driver.sv
// Converts a 24-bit RGB target into three registered PWM lines with optional
// per-period fading. Holds the shared prescaler and 8-bit period counter.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   light         in   target colour [23:16]=R [15:8]=G [7:0]=B
//   enable        in   1 runs PWM; 0 clears counters and forces outputs low
//   pwm_r/g/b     out  registered PWM drives
//   period_start  out  high in the first cycle of each PWM period
//   cur_rgb       out  current faded levels, same byte order as light
//   settled       out  cur_rgb equals light
module light_pwm_driver
    import light_pkg::*;
#(
    parameter int unsigned PRESCALE  = 4,
    parameter bit          FADE_EN   = 1'b1,
    parameter int unsigned FADE_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] light,
    input  logic        enable,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        period_start,
    output logic [23:0] cur_rgb,
    output logic        settled
);

    // Keep at least one bit so PRESCALE=1 still elaborates.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_W-1:0] CNT_LAST = '1;

    logic [PS_W-1:0]  r_presc;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic             w_tick;
    logic             w_update;
    logic [PWM_W-1:0] w_lvl_r;
    logic [PWM_W-1:0] w_lvl_g;
    logic [PWM_W-1:0] w_lvl_b;

    assign w_tick   = (r_presc == PS_LAST);
    assign w_update = enable && w_tick && (r_pwm_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_presc   <= '0;
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    assign period_start = enable && (r_presc == '0) && (r_pwm_cnt == '0);

    pwm_channel #(
        .FADE_EN   (FADE_EN),
        .FADE_STEP (FADE_STEP)
    ) u_ch_r (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .update  (w_update),
        .target  (light[R_HI:R_LO]),
        .pwm_cnt (r_pwm_cnt),
        .level   (w_lvl_r),
        .pwm     (pwm_r)
    );

    pwm_channel #(
        .FADE_EN   (FADE_EN),
        .FADE_STEP (FADE_STEP)
    ) u_ch_g (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .update  (w_update),
        .target  (light[G_HI:G_LO]),
        .pwm_cnt (r_pwm_cnt),
        .level   (w_lvl_g),
        .pwm     (pwm_g)
    );

    pwm_channel #(
        .FADE_EN   (FADE_EN),
        .FADE_STEP (FADE_STEP)
    ) u_ch_b (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .update  (w_update),
        .target  (light[B_HI:B_LO]),
        .pwm_cnt (r_pwm_cnt),
        .level   (w_lvl_b),
        .pwm     (pwm_b)
    );

    assign cur_rgb = {w_lvl_r, w_lvl_g, w_lvl_b};
    assign settled = (cur_rgb == light);

endmodule

// File: tb/tb_light_pwm_driver.sv
// Bench for light_pwm_driver: three instances (jump, fade step 1, fade step 4)
// share stimulus and are compared every cycle against a period-level model.
module tb_light_pwm_driver;

    localparam int P   = 2;
    localparam int PER = 256 * P;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] light;

    logic [2:0][2:0]  pwm_v;
    logic [2:0][23:0] cur_v;
    logic [2:0]       ps_v;
    logic [2:0]       st_v;

    int fen [3] = '{0, 1, 1};
    int stp [3] = '{1, 1, 4};

    int cur_m [3];
    int k;
    int hi0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    light_pwm_driver #(.PRESCALE(P), .FADE_EN(1'b0), .FADE_STEP(1)) dut0 (
        .clk(clk), .rst(rst), .light(light), .enable(enable),
        .pwm_r(pwm_v[0][2]), .pwm_g(pwm_v[0][1]), .pwm_b(pwm_v[0][0]),
        .period_start(ps_v[0]), .cur_rgb(cur_v[0]), .settled(st_v[0])
    );

    light_pwm_driver #(.PRESCALE(P), .FADE_EN(1'b1), .FADE_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .light(light), .enable(enable),
        .pwm_r(pwm_v[1][2]), .pwm_g(pwm_v[1][1]), .pwm_b(pwm_v[1][0]),
        .period_start(ps_v[1]), .cur_rgb(cur_v[1]), .settled(st_v[1])
    );

    light_pwm_driver #(.PRESCALE(P), .FADE_EN(1'b1), .FADE_STEP(4)) dut2 (
        .clk(clk), .rst(rst), .light(light), .enable(enable),
        .pwm_r(pwm_v[2][2]), .pwm_g(pwm_v[2][1]), .pwm_b(pwm_v[2][0]),
        .period_start(ps_v[2]), .cur_rgb(cur_v[2]), .settled(st_v[2])
    );

    task automatic chk(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int byte_of(input int v, input int ch);
        return (v >> (8 * (2 - ch))) & 255;
    endfunction

    // Move by the gap, clamped to +/- step.
    function automatic int fadef(input int cur, input int tgt,
                                 input int f, input int s);
        int d;
        if (f == 0) return tgt;
        d = tgt - cur;
        if (d > s) d = s;
        if (d < -s) d = -s;
        return cur + d;
    endfunction

    // k = enabled edges since the last reset/disable; position in the
    // period is k mod PER, counter value is position / P.
    task automatic step();
        logic [2:0] ep [3];
        int nv;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            for (int ch = 0; ch < 3; ch++) begin
                ep[d][2-ch] = !rst && enable &&
                              (((k % PER) / P) < byte_of(cur_m[d], ch));
            end
        end
        if (rst) begin
            k = 0;
            for (int d = 0; d < 3; d++) cur_m[d] = 0;
        end else if (!enable) begin
            k = 0;
        end else begin
            if (k % PER == PER - 1) begin
                for (int d = 0; d < 3; d++) begin
                    nv = 0;
                    for (int ch = 0; ch < 3; ch++) begin
                        nv = (nv << 8) |
                             fadef(byte_of(cur_m[d], ch),
                                   byte_of(int'(light), ch), fen[d], stp[d]);
                    end
                    cur_m[d] = nv;
                end
            end
            k++;
        end
        #1;
        if (pwm_v[0][2]) hi0++;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("pwm%0d", d), 24'(pwm_v[d]), 24'(ep[d]));
            chk($sformatf("cur%0d", d), cur_v[d], 24'(cur_m[d]));
            chk($sformatf("pstart%0d", d), 24'(ps_v[d]),
                24'(enable && (k % PER == 0)));
            chk($sformatf("settled%0d", d), 24'(st_v[d]),
                24'(cur_m[d] == int'(light)));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        k = 0;
        hi0 = 0;
        for (int d = 0; d < 3; d++) cur_m[d] = 0;
        rst = 1'b1;
        enable = 1'b0;
        light = 24'h0;
        step();
        chk("reset_cur", cur_v[0], 24'h0);

        // Full white, jump mode reaches target after one period.
        rst = 1'b0;
        enable = 1'b1;
        light = 24'hFF_FFFF;
        run(PER);
        chk("white_cur", cur_v[0], 24'hFF_FFFF);
        chk("white_fade1", cur_v[1], 24'h01_0101);
        hi0 = 0;
        run(PER);
        chk("white_hi", 24'(hi0), 24'd510);

        // Fade from 0 to 0x0A, one step per period; reset held with enable.
        rst = 1'b1;
        step();
        rst = 1'b0;
        light = 24'h0A_0000;
        for (int p = 0; p < 10; p++) begin
            run(PER);
            chk("fade_r", cur_v[1], 24'((p + 1) << 16));
        end
        chk("fade_settled", 24'(st_v[1]), 24'd1);

        // Mid-period target change only affects the next period.
        light = 24'h80_0000;
        run(PER);
        chk("r80_cur", cur_v[0], 24'h80_0000);
        hi0 = 0;
        run(100);
        light = 24'h40_0000;
        run(PER - 100);
        chk("hi_80", 24'(hi0), 24'd256);
        hi0 = 0;
        run(PER);
        chk("hi_40", 24'(hi0), 24'd128);

        // Step 4 from 02 down to 00 must not wrap.
        rst = 1'b1;
        step();
        rst = 1'b0;
        light = 24'h02_0000;
        run(PER);
        chk("s4_up", cur_v[2], 24'h02_0000);
        light = 24'h00_0000;
        run(PER);
        chk("s4_down", cur_v[2], 24'h00_0000);

        // Disable mid-period, then re-enable.
        light = 24'hC0_3060;
        run(PER + 100);
        enable = 1'b0;
        step();
        chk("dis_pwm", 24'({pwm_v[0], pwm_v[1], pwm_v[2]}), 24'h0);
        chk("dis_hold", cur_v[0], 24'hC0_3060);
        run(20);
        enable = 1'b1;
        #1;
        chk("reen_ps", 24'(ps_v), 24'h7);
        run(600);

        // Reset mid-period while enabled.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_cur", cur_v[1], 24'h0);
        chk("rst_pwm", 24'({pwm_v[0], pwm_v[1], pwm_v[2]}), 24'h0);

        // Random targets with occasional disable gaps.
        for (int i = 0; i < 8; i++) begin
            light = 24'($urandom);
            run(int'($urandom_range(50, 700)));
            if ($urandom_range(0, 2) == 0) begin
                enable = 1'b0;
                run(int'($urandom_range(1, 10)));
                enable = 1'b1;
            end
        end
        run(PER);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
